// File: rtl/spike_vector_packer.sv
// Collects serial per-neuron spike beats into a shadow vector and publishes it with a one-cycle strobe.
// Define SPIKE_VECTOR_PACKER_ORDER_CHECK_EN to drop out-of-order beats and raise a sticky err_o.
module spike_vector_packer #(
   parameter int NUM_NEURONS = 256,
   parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   tick_i,
   input  logic                   neuron_valid_i,
   input  logic [IDX_W-1:0]       neuron_idx_i,
   input  logic                   spike_i,
   output logic                   ready_o,
   output logic                   busy_o,
   output logic [NUM_NEURONS-1:0] spike_vector_o,
   output logic [IDX_W:0]         spike_count_o,
   output logic                   enable_calc_o,
   output logic                   err_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PUBLISH = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [NUM_NEURONS-1:0] shadow_q, shadow_d;
   logic [NUM_NEURONS-1:0] vector_q, vector_d;
   logic [IDX_W:0]         cnt_q, cnt_d;
   logic [IDX_W:0]         count_q, count_d;
   logic [IDX_W:0]         shadow_pop;
   logic                   strobe_q, strobe_d;
   logic                   in_order;
`ifdef SPIKE_VECTOR_PACKER_ORDER_CHECK_EN
   logic                   err_q, err_d;
`endif

   always_comb begin
      shadow_pop = '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
         shadow_pop = shadow_pop + {{IDX_W{1'b0}}, shadow_q[k]};
      end
   end

`ifdef SPIKE_VECTOR_PACKER_ORDER_CHECK_EN
   assign in_order = (neuron_idx_i == cnt_q[IDX_W-1:0]);
`else
   assign in_order = 1'b1;
`endif

   // A tick always beats a same-cycle beat; PUBLISH ignores both.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      vector_d = vector_q;
      cnt_d    = cnt_q;
      count_d  = count_q;
      strobe_d = 1'b0;
`ifdef SPIKE_VECTOR_PACKER_ORDER_CHECK_EN
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (tick_i) begin
               shadow_d = '0;
               cnt_d    = '0;
               state_d  = COLLECT;
`ifdef SPIKE_VECTOR_PACKER_ORDER_CHECK_EN
               err_d    = 1'b0;
`endif
            end
         end
         COLLECT: begin
            if (tick_i) begin
               shadow_d = '0;
               cnt_d    = '0;
`ifdef SPIKE_VECTOR_PACKER_ORDER_CHECK_EN
               err_d    = 1'b0;
`endif
            end else if (neuron_valid_i) begin
               if (in_order) begin
                  for (int k = 0; k < NUM_NEURONS; k++) begin
                     if (neuron_idx_i == IDX_W'(k)) begin
                        shadow_d[NUM_NEURONS-1-k] = spike_i;
                     end
                  end
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == (IDX_W+1)'(NUM_NEURONS-1)) begin
                     state_d = PUBLISH;
                  end
               end else begin
`ifdef SPIKE_VECTOR_PACKER_ORDER_CHECK_EN
                  err_d = 1'b1;
`endif
               end
            end
         end
         PUBLISH: begin
            vector_d = shadow_q;
            count_d  = shadow_pop;
            strobe_d = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         vector_q <= '0;
         cnt_q    <= '0;
         count_q  <= '0;
         strobe_q <= 1'b0;
`ifdef SPIKE_VECTOR_PACKER_ORDER_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         vector_q <= vector_d;
         cnt_q    <= cnt_d;
         count_q  <= count_d;
         strobe_q <= strobe_d;
`ifdef SPIKE_VECTOR_PACKER_ORDER_CHECK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign ready_o        = (state_q == COLLECT);
   assign busy_o         = (state_q != IDLE);
   assign spike_vector_o = vector_q;
   assign spike_count_o  = count_q;
   assign enable_calc_o  = strobe_q;
`ifdef SPIKE_VECTOR_PACKER_ORDER_CHECK_EN
   assign err_o          = err_q;
`else
   assign err_o          = 1'b0;
`endif

endmodule
